// File: rtl/dmem_arbiter.sv
// Two-requester (core / debug-DMA) round-robin arbiter in front of a single-port data memory.
// Optional WAIT-state timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    // core requester
    input  logic        c_request,
    input  logic        c_we_re,
    input  logic [3:0]  c_mask,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_valid,
    output logic [31:0] c_rdata,
    output logic        c_err,
    output logic        c_stall,
    // debug/DMA requester
    input  logic        d_request,
    input  logic        d_we_re,
    input  logic [3:0]  d_mask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    // memory side
    output logic        m_request,
    output logic        m_we_re,
    output logic [3:0]  m_mask,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_valid,
    input  logic [31:0] m_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_DBG  = 1'b1;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("dmem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0] state;
    logic [1:0] next_state;
    logic       grant;
    logic       last_grant;
    logic       winner_c;
    logic       any_req_c;
    logic       timeout_c;

    assign any_req_c = c_request | d_request;
    // On a tie the requester that did not win last time gets the bus.
    assign winner_c  = (c_request && d_request) ? ~last_grant
                     : (d_request ? GNT_DBG : GNT_CORE);

    assign c_stall = c_request & ~((state == RESP) && (grant == GNT_CORE));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // m_valid on the terminal count wins over the timeout.
    assign timeout_c = (state == WAIT) && !m_valid
                     && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Error flags pulse only alongside valid in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_err <= 1'b0;
            d_err <= 1'b0;
        end else begin
            c_err <= timeout_c && (grant == GNT_CORE);
            d_err <= timeout_c && (grant == GNT_DBG);
        end
    end
`else
    assign timeout_c = 1'b0;
    assign c_err     = 1'b0;
    assign d_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req_c) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (m_valid || timeout_c) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs, grant bookkeeping and response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= GNT_CORE;
            last_grant <= GNT_DBG;
            m_request  <= 1'b0;
            m_we_re    <= 1'b0;
            m_mask     <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            c_valid    <= 1'b0;
            d_valid    <= 1'b0;
            c_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            m_request <= (next_state == ISSUE);
            c_valid   <= (next_state == RESP) && (grant == GNT_CORE);
            d_valid   <= (next_state == RESP) && (grant == GNT_DBG);

            if ((state == IDLE) && any_req_c) begin
                grant      <= winner_c;
                last_grant <= winner_c;
                m_we_re    <= winner_c ? d_we_re : c_we_re;
                m_mask     <= winner_c ? d_mask  : c_mask;
                m_addr     <= winner_c ? d_addr  : c_addr;
                m_wdata    <= winner_c ? d_wdata : c_wdata;
            end

            if ((state == WAIT) && m_valid && !m_we_re) begin
                if (grant == GNT_CORE) c_rdata <= m_rdata;
                else                   d_rdata <= m_rdata;
            end else if (timeout_c) begin
                if (grant == GNT_CORE) c_rdata <= '0;
                else                   d_rdata <= '0;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, WAIT-state cycles before a transaction is aborted (used only under REQ-030).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset; all other ports follow.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  asynchronous reset, active high.
REQ-005 Ports, core requester (prefix c_), memory-stage side: request in 1, we_re in 1 (1=store), mask in 4, addr in 32, wdata in 32.
REQ-006 Ports, core response: c_valid out 1 (completion pulse), c_rdata out 32, c_err out 1, c_stall out 1.
REQ-007 Ports, debug/DMA requester (prefix d_): the same five inputs as REQ-005, plus d_valid out 1, d_rdata out 32, d_err out 1.
REQ-008 Ports, memory side: m_request out 1, m_we_re out 1, m_mask out 4, m_addr out 32, m_wdata out 32, m_valid in 1, m_rdata in 32.

Function
REQ-010 Requesters SHALL hold request and payload stable from assertion until their valid pulse; the block samples the payload once, at grant.
REQ-011 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-012 IDLE: if any request is high, SHALL latch the winner's we_re, mask, addr and wdata plus a grant ID, then go to ISSUE; otherwise stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: a single request wins; if both are high, the requester not granted last wins; last_grant updates at each grant.
REQ-014 ISSUE: for exactly one cycle, m_request=1 and m_we_re/m_mask/m_addr/m_wdata SHALL drive the latched payload; then go to WAIT.
REQ-015 m_request SHALL be 0 in every state except ISSUE; the m_ payload outputs SHALL hold their latched values in all states.
REQ-016 WAIT: on m_valid=1, SHALL go to RESP and, for loads only, capture m_rdata into the granted requester's rdata register.
REQ-017 m_valid SHALL be ignored outside WAIT.
REQ-018 RESP: the granted requester's valid SHALL be 1 for exactly this one cycle; requests SHALL be ignored; next state is IDLE.
REQ-019 For stores, the requester's rdata SHALL stay unchanged; the non-granted requester's rdata SHALL never change.
REQ-020 Minimum latency, request high in cycle 0 with m_valid in cycle 2: ISSUE in cycle 1, WAIT in cycle 2, valid in cycle 3.
REQ-021 c_stall SHALL be combinational: c_request AND NOT (state==RESP AND grant==core).
REQ-022 A request that drops before its grant SHALL be treated as never made; one that drops after its grant SHALL still complete.

Reset
REQ-025 Asserting rst SHALL immediately force: state IDLE, last_grant=debug (the core wins the first tie), all valid/err/m_request outputs 0, all rdata and m_ payload registers 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no valid pulse; an m_valid arriving after reset release SHALL be ignored (REQ-017).

Configuration
REQ-030 With MEM_ARB_TIMEOUT_EN defined, WAIT SHALL count cycles from 0; after TIMEOUT_CYCLES cycles without m_valid, it SHALL go to RESP with the requester's err=1 and rdata=0.
REQ-031 Under MEM_ARB_TIMEOUT_EN, if m_valid arrives on the terminal count cycle, normal completion (err=0) SHALL take priority.
REQ-032 Under MEM_ARB_TIMEOUT_EN, err SHALL pulse only alongside valid in RESP.
REQ-033 Without MEM_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter SHALL exist, and c_err/d_err SHALL be constant 0.

Verification
REQ-040 Core load, addr 0x100, memory returns 0xCAFEBABE one cycle after m_request -> c_valid pulses in cycle 3, c_rdata=0xCAFEBABE, c_stall high in cycles 0-2.
REQ-041 Core and debug request in the same cycle after reset -> core granted first, debug second; after the debug store, a repeat collision grants the core.
REQ-042 Debug store, mask 4'b0011, wdata 0x1234 -> m_request high for one cycle with m_we_re=1, m_mask=4'b0011, m_wdata=0x1234; d_rdata unchanged.
REQ-043 m_valid pulsed during ISSUE, then again 4 cycles later -> the first pulse is ignored; completion occurs on the second.
REQ-044 rst asserted during WAIT -> all outputs 0 immediately; a late m_valid produces no valid pulse.
REQ-045 MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, memory never answers -> c_valid=1, c_err=1, c_rdata=0 in one RESP cycle, then IDLE.
